forwarding_bypass_unit: RTL and testbench
=========================================

# forwarding_bypass_unit

Parametrised operand bypass network for the EXE stage: selects, per source operand, the freshest value of a register from the MEM stage, the WB stage, or a small history buffer of recently retired writebacks, falling back to the register-file value latched in ID/EXE. The history buffer closes the write-then-read window of a posedge-write register file. It replaces the fixed two-source MEM/WB select logic and drives the EXE operand muxes directly.

## Interface
Parameters:
- REG_W, 4, register index width
- DATA_W, 32, operand width
- NUM_SRC, 2, number of source operands compared (3 for register-shifted operands)
- DEPTH, 2, history entries, ≥1
- CNT_W, 32, statistics counter width (FWD_STATS_EN only)
- SEL_W, $clog2(DEPTH+3), derived, select code width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- src  in  NUM_SRC*REG_W  source register indices; operand i at bits [i*REG_W +: REG_W]
- src_valid  in  NUM_SRC  operand i actually reads a register
- rf_val  in  NUM_SRC*DATA_W  register-file values from ID/EXE
- MEM_dest  in  REG_W  MEM-stage destination
- MEM_WB_en  in  1  MEM-stage instruction will write back
- MEM_val  in  DATA_W  MEM-stage ALU result
- WB_dest  in  REG_W  WB-stage destination
- WB_WB_en  in  1  WB-stage write enable to register file
- WB_val  in  DATA_W  WB-stage writeback value
- exe_valid  in  1  EXE holds a real instruction (not bubble)
- freeze  in  1  EXE stage stalled this cycle
- sel  out  NUM_SRC*SEL_W  per-operand select code
- fwd_val  out  NUM_SRC*DATA_W  per-operand forwarded operand
- fwd_mem_cnt, fwd_wb_cnt, fwd_hist_cnt  out  CNT_W each  hit counters (FWD_STATS_EN only)

## Operation
- Select codes: 0 = rf_val, 1 = MEM, 2 = WB, 3+k = history entry k (k=0 newest).
- Priority per operand, highest first: MEM match (src==MEM_dest & MEM_WB_en), WB match (src==WB_dest & WB_WB_en), history entries newest→oldest (valid & tag match), rf_val.
- src_valid[i]=0 forces sel=0, fwd_val=rf_val for operand i.
- History: DEPTH entries of {valid, tag, data}. On a rising edge with WB_WB_en=1: entry 0 ← {1, WB_dest, WB_val}, entry k ← entry k-1, oldest dropped. WB_WB_en=0: hold.
- freeze does not affect history push (writebacks still retire); duplicate tags allowed, newest wins by priority.
- Reset: all history valid bits 0; counters 0. sel/fwd_val are combinational; with all enables low they read 0 / rf_val.

## Timing
- sel and fwd_val: zero-latency combinational from inputs and current history state.
- History entry written at edge N is visible to comparisons from cycle N+1.
- Same-cycle WB write and match: served by WB path (code 2), not history.
- Reset asserted mid-operation clears history immediately (async); first push after deassertion fills entry 0 only.
- Covers stalls of at most DEPTH retired writes between ID read and EXE use; longer exposure is a hazard-unit obligation.

## Configuration
- FWD_STATS_EN defined: three saturating counters, each incremented by the number of operands (exe_valid=1, freeze=0) selecting MEM, WB, or any history entry that cycle; saturate at all-ones; cleared by reset.
- Undefined: counter ports and logic absent; forwarding behaviour identical.

## Test plan
- Reset, rf_val={0x11,0x22}, all enables low -> sel={0,0}, fwd_val={0x11,0x22}.
- src={3,3}, MEM_dest=3 MEM_WB_en=1 MEM_val=0xA, WB_dest=3 WB_WB_en=1 WB_val=0xB -> both sel=1, fwd_val=0xA (MEM over WB).
- Push WB r5=0x55 then r6=0x66 (DEPTH=2), next cycle src={5,6}, no MEM/WB match -> sel={4,3}, fwd_val={0x55,0x66}; third push r7 -> r5 dropped, src=5 gives sel=0.
- Push r4=0x1 then r4=0x2, src=4 -> sel=3, fwd_val=0x2 (newest wins); src_valid=0 -> sel=0.
- Reset asserted with history full, release -> src matching old tags gives sel=0.
- FWD_STATS_EN, 3 cycles of MEM hits on both operands, one cycle with freeze=1 -> fwd_mem_cnt=6; CNT_W=2 -> saturates at 3.

Source files
------------

// File: rtl/forwarding_bypass_unit.sv
// forwarding_bypass_unit: EXE operand bypass from MEM, WB or a short history of retired writebacks.
// Define FWD_STATS_EN to add saturating MEM/WB/history hit counters.
module forwarding_bypass_unit #(
  parameter int REG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 32,
  parameter int SEL_W   = $clog2(DEPTH + 3)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC*REG_W-1:0]    src,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]   rf_val,
  input  logic [REG_W-1:0]            MEM_dest,
  input  logic                        MEM_WB_en,
  input  logic [DATA_W-1:0]           MEM_val,
  input  logic [REG_W-1:0]            WB_dest,
  input  logic                        WB_WB_en,
  input  logic [DATA_W-1:0]           WB_val,
  input  logic                        exe_valid,
  input  logic                        freeze,
  output logic [NUM_SRC*SEL_W-1:0]    sel,
  output logic [NUM_SRC*DATA_W-1:0]   fwd_val
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0]            fwd_mem_cnt,
  output logic [CNT_W-1:0]            fwd_wb_cnt,
  output logic [CNT_W-1:0]            fwd_hist_cnt
`endif
);
  logic              hist_v_q    [DEPTH];
  logic [REG_W-1:0]  hist_tag_q  [DEPTH];
  logic [DATA_W-1:0] hist_data_q [DEPTH];
  logic              hist_v_d    [DEPTH];
  logic [REG_W-1:0]  hist_tag_d  [DEPTH];
  logic [DATA_W-1:0] hist_data_d [DEPTH];
  // Sources are applied lowest priority first so the freshest match overrides.
  always_comb begin
    sel = '0;
    fwd_val = rf_val;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i]) begin
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (hist_v_q[k] && hist_tag_q[k] == src[i*REG_W +: REG_W]) begin
            sel[i*SEL_W +: SEL_W] = SEL_W'(k + 3);
            fwd_val[i*DATA_W +: DATA_W] = hist_data_q[k];
          end
        end
        if (WB_WB_en && WB_dest == src[i*REG_W +: REG_W]) begin
          sel[i*SEL_W +: SEL_W] = SEL_W'(2);
          fwd_val[i*DATA_W +: DATA_W] = WB_val;
        end
        if (MEM_WB_en && MEM_dest == src[i*REG_W +: REG_W]) begin
          sel[i*SEL_W +: SEL_W] = SEL_W'(1);
          fwd_val[i*DATA_W +: DATA_W] = MEM_val;
        end
      end
    end
  end
  always_comb begin
    hist_v_d[0] = WB_WB_en ? 1'b1 : hist_v_q[0];
    hist_tag_d[0] = WB_WB_en ? WB_dest : hist_tag_q[0];
    hist_data_d[0] = WB_WB_en ? WB_val : hist_data_q[0];
    for (int k = 1; k < DEPTH; k++) begin
      hist_v_d[k] = WB_WB_en ? hist_v_q[k-1] : hist_v_q[k];
      hist_tag_d[k] = WB_WB_en ? hist_tag_q[k-1] : hist_tag_q[k];
      hist_data_d[k] = WB_WB_en ? hist_data_q[k-1] : hist_data_q[k];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        hist_v_q[k] <= 1'b0;
        hist_tag_q[k] <= '0;
        hist_data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        hist_v_q[k] <= hist_v_d[k];
        hist_tag_q[k] <= hist_tag_d[k];
        hist_data_q[k] <= hist_data_d[k];
      end
    end
  end
`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] mem_hits, wb_hits, hist_hits;
  logic [CNT_W-1:0] fwd_mem_cnt_q, fwd_wb_cnt_q, fwd_hist_cnt_q;
  logic [CNT_W-1:0] fwd_mem_cnt_d, fwd_wb_cnt_d, fwd_hist_cnt_d;
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction
  always_comb begin
    mem_hits = '0;
    wb_hits = '0;
    hist_hits = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      mem_hits = mem_hits + CNT_W'(sel[i*SEL_W +: SEL_W] == SEL_W'(1));
      wb_hits = wb_hits + CNT_W'(sel[i*SEL_W +: SEL_W] == SEL_W'(2));
      hist_hits = hist_hits + CNT_W'(sel[i*SEL_W +: SEL_W] >= SEL_W'(3));
    end
    fwd_mem_cnt_d = (exe_valid && !freeze) ? sat_add(fwd_mem_cnt_q, mem_hits) : fwd_mem_cnt_q;
    fwd_wb_cnt_d = (exe_valid && !freeze) ? sat_add(fwd_wb_cnt_q, wb_hits) : fwd_wb_cnt_q;
    fwd_hist_cnt_d = (exe_valid && !freeze) ? sat_add(fwd_hist_cnt_q, hist_hits) : fwd_hist_cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_mem_cnt_q <= '0;
      fwd_wb_cnt_q <= '0;
      fwd_hist_cnt_q <= '0;
    end else begin
      fwd_mem_cnt_q <= fwd_mem_cnt_d;
      fwd_wb_cnt_q <= fwd_wb_cnt_d;
      fwd_hist_cnt_q <= fwd_hist_cnt_d;
    end
  end
  assign fwd_mem_cnt = fwd_mem_cnt_q;
  assign fwd_wb_cnt = fwd_wb_cnt_q;
  assign fwd_hist_cnt = fwd_hist_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = ^{exe_valid, freeze, CNT_W};
`endif
endmodule

// File: tb/tb_forwarding_bypass_unit.sv
// tb_forwarding_bypass_unit: vector table, directed history sequences and randomized model comparison.
module tb_forwarding_bypass_unit;
  localparam int REG_W = 4, DATA_W = 32, NUM_SRC = 2, DEPTH = 2, CNT_W = 4;
  localparam int SEL_W = $clog2(DEPTH + 3);
  logic clk = 1'b0, rst = 1'b0;
  logic [NUM_SRC*REG_W-1:0] src;
  logic [NUM_SRC-1:0] src_valid;
  logic [NUM_SRC*DATA_W-1:0] rf_val;
  logic [REG_W-1:0] MEM_dest, WB_dest;
  logic MEM_WB_en, WB_WB_en, exe_valid, freeze;
  logic [DATA_W-1:0] MEM_val, WB_val;
  logic [NUM_SRC*SEL_W-1:0] sel;
  logic [NUM_SRC*DATA_W-1:0] fwd_val;
`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] fwd_mem_cnt, fwd_wb_cnt, fwd_hist_cnt;
`endif
  forwarding_bypass_unit #(.REG_W(REG_W), .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .src(src), .src_valid(src_valid), .rf_val(rf_val),
    .MEM_dest(MEM_dest), .MEM_WB_en(MEM_WB_en), .MEM_val(MEM_val),
    .WB_dest(WB_dest), .WB_WB_en(WB_WB_en), .WB_val(WB_val),
    .exe_valid(exe_valid), .freeze(freeze), .sel(sel), .fwd_val(fwd_val)
`ifdef FWD_STATS_EN
    , .fwd_mem_cnt(fwd_mem_cnt), .fwd_wb_cnt(fwd_wb_cnt), .fwd_hist_cnt(fwd_hist_cnt)
`endif
  );
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [REG_W-1:0] h_tag[$];
  logic [DATA_W-1:0] h_dat[$];
  int m_mem = 0, m_wb = 0, m_hist = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain priority search over a newest-first list of retired writes.
  function automatic int exp_sel(input int i);
    logic [REG_W-1:0] s;
    s = src[i*REG_W +: REG_W];
    if (!src_valid[i]) return 0;
    if (MEM_WB_en && s == MEM_dest) return 1;
    if (WB_WB_en && s == WB_dest) return 2;
    for (int k = 0; k < h_tag.size(); k++) if (h_tag[k] == s) return 3 + k;
    return 0;
  endfunction

  function automatic logic [DATA_W-1:0] exp_val(input int i, input int code);
    if (code == 0) return rf_val[i*DATA_W +: DATA_W];
    if (code == 1) return MEM_val;
    if (code == 2) return WB_val;
    return h_dat[code-3];
  endfunction

  task automatic check_model(input string name);
    int c;
    for (int i = 0; i < NUM_SRC; i++) begin
      c = exp_sel(i);
      chk($sformatf("%s sel%0d", name, i), 32'(sel[i*SEL_W +: SEL_W]), 32'(c));
      chk($sformatf("%s val%0d", name, i), fwd_val[i*DATA_W +: DATA_W], exp_val(i, c));
    end
`ifdef FWD_STATS_EN
    chk({name, " mem_cnt"}, 32'(fwd_mem_cnt), 32'(m_mem));
    chk({name, " wb_cnt"}, 32'(fwd_wb_cnt), 32'(m_wb));
    chk({name, " hist_cnt"}, 32'(fwd_hist_cnt), 32'(m_hist));
`endif
  endtask

  function automatic int sat(input int v);
    return (v > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v;
  endfunction

  task automatic tick();
    int c, nm, nw, nh;
    nm = 0; nw = 0; nh = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      c = exp_sel(i);
      nm += int'(c == 1); nw += int'(c == 2); nh += int'(c >= 3);
    end
    if (exe_valid && !freeze) begin
      m_mem = sat(m_mem + nm); m_wb = sat(m_wb + nw); m_hist = sat(m_hist + nh);
    end
    if (WB_WB_en) begin
      h_tag.push_front(WB_dest); h_dat.push_front(WB_val);
      if (h_tag.size() > DEPTH) begin void'(h_tag.pop_back()); void'(h_dat.pop_back()); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    src = '0; src_valid = '1; rf_val = '0; MEM_dest = '0; MEM_WB_en = 0; MEM_val = '0;
    WB_dest = '0; WB_WB_en = 0; WB_val = '0; exe_valid = 0; freeze = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    h_tag.delete(); h_dat.delete();
    m_mem = 0; m_wb = 0; m_hist = 0;
    #1;
    rst = 1;
    #1;
  endtask

  task automatic set_srcs(input logic [REG_W-1:0] s0, input logic [REG_W-1:0] s1);
    src = {s1, s0};
  endtask

  task automatic push(input logic [REG_W-1:0] d, input logic [DATA_W-1:0] v);
    WB_dest = d; WB_val = v; WB_WB_en = 1;
    #1;
    tick();
    WB_WB_en = 0;
  endtask

  typedef struct {
    logic [REG_W-1:0] s0, s1;
    logic [1:0] sv;
    logic [DATA_W-1:0] r0, r1;
    logic [REG_W-1:0] md; logic me; logic [DATA_W-1:0] mv;
    logic [REG_W-1:0] wd; logic we; logic [DATA_W-1:0] wv;
    int e_sel0, e_sel1;
    logic [DATA_W-1:0] e_v0, e_v1;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{0, 0, 2'b11, 32'h11, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11, 32'h22};
    vecs[1] = '{3, 3, 2'b11, 32'h11, 32'h22, 3, 1, 32'hA, 3, 1, 32'hB, 1, 1, 32'hA, 32'hA};
    vecs[2] = '{3, 4, 2'b11, 32'h11, 32'h22, 3, 1, 32'hA, 4, 1, 32'hB, 1, 2, 32'hA, 32'hB};
    vecs[3] = '{3, 4, 2'b01, 32'h11, 32'h22, 4, 1, 32'hA, 4, 1, 32'hB, 0, 0, 32'h11, 32'h22};
    vecs[4] = '{7, 7, 2'b11, 32'h1, 32'h2, 7, 0, 32'hA, 7, 1, 32'hC, 2, 2, 32'hC, 32'hC};
    vecs[5] = '{9, 2, 2'b11, 32'h5, 32'h6, 9, 0, 32'hA, 2, 0, 32'hB, 0, 0, 32'h5, 32'h6};
    clear_inputs();
    #2;
    do_reset();
    for (int v = 0; v < 6; v++) begin
      do_reset();
      set_srcs(vecs[v].s0, vecs[v].s1);
      src_valid = vecs[v].sv; rf_val = {vecs[v].r1, vecs[v].r0};
      MEM_dest = vecs[v].md; MEM_WB_en = vecs[v].me; MEM_val = vecs[v].mv;
      WB_dest = vecs[v].wd; WB_WB_en = vecs[v].we; WB_val = vecs[v].wv;
      #1;
      chk($sformatf("vec%0d sel0", v), 32'(sel[0 +: SEL_W]), 32'(vecs[v].e_sel0));
      chk($sformatf("vec%0d sel1", v), 32'(sel[SEL_W +: SEL_W]), 32'(vecs[v].e_sel1));
      chk($sformatf("vec%0d val0", v), fwd_val[0 +: DATA_W], vecs[v].e_v0);
      chk($sformatf("vec%0d val1", v), fwd_val[DATA_W +: DATA_W], vecs[v].e_v1);
      @(negedge clk);
    end

    do_reset();
    @(posedge clk); #1;
    push(5, 32'h55);
    push(6, 32'h66);
    set_srcs(5, 6); rf_val = {32'hE1, 32'hE0};
    #1;
    chk("hist sel0", 32'(sel[0 +: SEL_W]), 4);
    chk("hist sel1", 32'(sel[SEL_W +: SEL_W]), 3);
    chk("hist val0", fwd_val[0 +: DATA_W], 32'h55);
    chk("hist val1", fwd_val[DATA_W +: DATA_W], 32'h66);
    check_model("hist model");
    push(7, 32'h77);
    #1;
    chk("drop sel0", 32'(sel[0 +: SEL_W]), 0);
    chk("drop val0", fwd_val[0 +: DATA_W], 32'hE0);
    chk("drop sel1", 32'(sel[SEL_W +: SEL_W]), 4);

    do_reset();
    @(posedge clk); #1;
    push(4, 32'h1);
    push(4, 32'h2);
    set_srcs(4, 4); rf_val = {32'hD1, 32'hD0};
    #1;
    chk("dup sel0", 32'(sel[0 +: SEL_W]), 3);
    chk("dup val0", fwd_val[0 +: DATA_W], 32'h2);
    src_valid = 2'b10;
    #1;
    chk("srcv sel0", 32'(sel[0 +: SEL_W]), 0);
    chk("srcv val0", fwd_val[0 +: DATA_W], 32'hD0);
    chk("srcv sel1", 32'(sel[SEL_W +: SEL_W]), 3);
    src_valid = 2'b11; WB_dest = 4; WB_val = 32'h9; WB_WB_en = 1;
    #1;
    chk("wb over hist sel0", 32'(sel[0 +: SEL_W]), 2);
    chk("wb over hist val0", fwd_val[0 +: DATA_W], 32'h9);
    WB_WB_en = 0;
    #1;
    rst = 0;
    #1;
    chk("async rst sel0", 32'(sel[0 +: SEL_W]), 0);
    do_reset();
    set_srcs(4, 4); rf_val = {32'hD1, 32'hD0};
    #1;
    chk("post rst sel0", 32'(sel[0 +: SEL_W]), 0);
    chk("post rst val1", fwd_val[DATA_W +: DATA_W], 32'hD1);
    @(posedge clk); #1;
    push(8, 32'h88);
    set_srcs(8, 4);
    #1;
    chk("first push sel0", 32'(sel[0 +: SEL_W]), 3);
    chk("first push sel1", 32'(sel[SEL_W +: SEL_W]), 0);

`ifdef FWD_STATS_EN
    do_reset();
    @(posedge clk); #1;
    set_srcs(3, 3); MEM_dest = 3; MEM_WB_en = 1; exe_valid = 1;
    for (int c = 0; c < 4; c++) begin
      freeze = (c == 2);
      #1;
      tick();
    end
    freeze = 0;
    chk("stats mem6", 32'(fwd_mem_cnt), 6);
    for (int c = 0; c < 6; c++) tick();
    chk("stats sat", 32'(fwd_mem_cnt), 15);
    chk("stats wb0", 32'(fwd_wb_cnt), 0);
`endif

    do_reset();
    @(posedge clk); #1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
        check_model("rand reset");
      end
      set_srcs(REG_W'($urandom_range(0, 7)), REG_W'($urandom_range(0, 7)));
      src_valid = NUM_SRC'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) src_valid = '1;
      rf_val = {$urandom, $urandom};
      MEM_dest = REG_W'($urandom_range(0, 7)); MEM_WB_en = ($urandom_range(0, 3) == 0); MEM_val = $urandom;
      WB_dest = REG_W'($urandom_range(0, 7)); WB_WB_en = ($urandom_range(0, 1) == 0); WB_val = $urandom;
      exe_valid = ($urandom_range(0, 4) != 0); freeze = ($urandom_range(0, 4) == 0);
      #1;
      check_model("rand");
      tick();
    end
    check_model("rand final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
